// File: rtl/rv_decode_pkg.sv
// -----------------------------------------------------------------------------
// rv_decode_pkg
// Shared definitions for the RV32I decode stage:
//   - opcode constants for every base-ISA major opcode the stage recognises
//   - func7 encodings accepted for R-format instructions
//   - fmt_e, the instruction-format enumeration (R/I/S/B/U/J/UNK)
//   - sext_imm(), a width-generic sign extension to MAX_XLEN bits
// Optional feature macro used by the importing files: INST_DECODE_ILLEGAL_CHK_EN
// -----------------------------------------------------------------------------
package rv_decode_pkg;

   localparam int MAX_XLEN = 64;

   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_UNK = 3'd7
   } fmt_e;

   // Sign-extends the low 'width' bits of raw (1..32) to MAX_XLEN bits.
   // Left-justify, then arithmetic shift back down so the top bit of the
   // field is replicated; callers truncate to their own XLEN.
   function automatic logic [MAX_XLEN-1:0] sext_imm(input logic [31:0] raw,
                                                   input int unsigned width);
      logic [MAX_XLEN-1:0] t;
      t = {32'b0, raw} << (MAX_XLEN - width);
      return $signed(t) >>> (MAX_XLEN - width);
   endfunction

endpackage

// File: rtl/inst_decode_stage_imm_gen.sv
// -----------------------------------------------------------------------------
// imm_gen
// Combinational format classification and immediate generation for one
// 32-bit RV32I instruction word.
// Parameters:
//   XLEN  immediate width, 32 or 64
// Ports:
//   inst  in   32    raw instruction word
//   fmt   out  fmt_e format class derived from inst[6:0]
//   imm   out  XLEN  sign-extended immediate (0 for R and UNK formats)
// Optional feature macro: INST_DECODE_ILLEGAL_CHK_EN (not used in this file)
// -----------------------------------------------------------------------------
module imm_gen
   import rv_decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst,
   output fmt_e            fmt,
   output logic [XLEN-1:0] imm
);

   logic [31:0] raw;
   int unsigned width;

   always_comb begin
      fmt = FMT_UNK;
      case (inst[6:0])
         OP_OP:                                fmt = FMT_R;
         OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:  fmt = FMT_I;
         OP_STORE:                             fmt = FMT_S;
         OP_BRANCH:                            fmt = FMT_B;
         OP_LUI, OP_AUIPC:                     fmt = FMT_U;
         OP_JAL:                               fmt = FMT_J;
         default:                              fmt = FMT_UNK;
      endcase
   end

   // Gather the scattered immediate bits into a right-justified field and
   // remember how wide it is; one shared sign extender does the rest.
   always_comb begin
      raw   = 32'b0;
      width = 32;
      case (fmt)
         FMT_I: begin
            raw   = {20'b0, inst[31:20]};
            width = 12;
         end
         FMT_S: begin
            raw   = {20'b0, inst[31:25], inst[11:7]};
            width = 12;
         end
         FMT_B: begin
            raw   = {19'b0, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            width = 13;
         end
         FMT_U: begin
            raw   = {inst[31:12], 12'b0};
            width = 32;
         end
         FMT_J: begin
            raw   = {11'b0, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            width = 21;
         end
         default: begin
            raw   = 32'b0;
            width = 32;
         end
      endcase
   end

   assign imm = XLEN'(sext_imm(raw, width));

endmodule

// File: rtl/inst_decode_stage.sv
// -----------------------------------------------------------------------------
// inst_decode_stage
// Registered RV32I decode stage between fetch and register-file/execute.
// Splits the instruction into raw fields, classifies its format, produces the
// sign-extended immediate and passes the PC through, all behind one register.
// Parameters:
//   XLEN  immediate width (32 or 64)
//   PC_W  PC passthrough width
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready upstream handshake; in_inst, in_pc carried with it
//   flush             kills the held bundle and the incoming instruction
//   out_valid/out_ready downstream handshake
//   opcode, func3, func7, rs1, rs2, rd   raw instruction fields
//   fmt               format code R=0 I=1 S=2 B=3 U=4 J=5 UNK=7
//   imm               sign-extended immediate
//   pc                registered in_pc
//   illegal           unsupported-encoding flag
// Optional feature macro: INST_DECODE_ILLEGAL_CHK_EN
//   defined   -> illegal is computed and registered with the bundle
//   undefined -> illegal is tied to 0
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready = !out_valid || out_ready, so the single register accepts a
// new instruction whenever it is empty or being drained in the same cycle.
// flush wins over everything: out_valid drops, nothing is captured, and the
// data registers keep their old contents.
// -----------------------------------------------------------------------------
module inst_decode_stage
   import rv_decode_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int PC_W = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [PC_W-1:0] in_pc,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [6:0]      opcode,
   output logic [2:0]      func3,
   output logic [6:0]      func7,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic [2:0]      fmt,
   output logic [XLEN-1:0] imm,
   output logic [PC_W-1:0] pc,
   output logic            illegal
);

   fmt_e            fmt_next;
   logic [XLEN-1:0] imm_next;
   logic            accept;

   imm_gen #(
      .XLEN (XLEN)
   ) u_imm_gen (
      .inst (in_inst),
      .fmt  (fmt_next),
      .imm  (imm_next)
   );

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opcode <= '0;
         func3  <= '0;
         func7  <= '0;
         rs1    <= '0;
         rs2    <= '0;
         rd     <= '0;
         fmt    <= FMT_UNK;
         imm    <= '0;
         pc     <= '0;
      end else if (accept) begin
         opcode <= in_inst[6:0];
         func3  <= in_inst[14:12];
         func7  <= in_inst[31:25];
         rs1    <= in_inst[19:15];
         rs2    <= in_inst[24:20];
         rd     <= in_inst[11:7];
         fmt    <= fmt_next;
         imm    <= imm_next;
         pc     <= in_pc;
      end
   end

`ifdef INST_DECODE_ILLEGAL_CHK_EN
   logic illegal_next;

   // Unknown opcode, an R-type func7 outside the two base encodings, or a
   // JALR whose func3 is not 000.
   always_comb begin
      illegal_next = 1'b0;
      if (fmt_next == FMT_UNK) begin
         illegal_next = 1'b1;
      end else if ((fmt_next == FMT_R) &&
                   (in_inst[31:25] != F7_BASE) && (in_inst[31:25] != F7_ALT)) begin
         illegal_next = 1'b1;
      end else if ((in_inst[6:0] == OP_JALR) && (in_inst[14:12] != 3'b000)) begin
         illegal_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal <= 1'b0;
      end else if (accept) begin
         illegal <= illegal_next;
      end
   end
`else
   assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_inst_decode_stage.sv
module tb_inst_decode_stage;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- stimulus / DUT signals ----------------
   logic        in_valid = 1'b0;
   logic [31:0] in_inst  = '0;
   logic [31:0] in_pc    = '0;
   logic        flush    = 1'b0;
   logic        out_ready = 1'b1;

   logic        in_ready, out_valid, illegal;
   logic [6:0]  opcode, func7;
   logic [2:0]  func3, fmt;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] imm, pc;

   logic        in_ready64, out_valid64, illegal64;
   logic [6:0]  opcode64, func7_64;
   logic [2:0]  func3_64, fmt64;
   logic [4:0]  rs1_64, rs2_64, rd64;
   logic [63:0] imm64;
   logic [31:0] pc64;

   inst_decode_stage #(.XLEN(32), .PC_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .opcode(opcode), .func3(func3), .func7(func7),
      .rs1(rs1), .rs2(rs2), .rd(rd), .fmt(fmt), .imm(imm), .pc(pc),
      .illegal(illegal)
   );

   inst_decode_stage #(.XLEN(64), .PC_W(32)) dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
      .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid64),
      .out_ready(out_ready), .opcode(opcode64), .func3(func3_64), .func7(func7_64),
      .rs1(rs1_64), .rs2(rs2_64), .rd(rd64), .fmt(fmt64), .imm(imm64), .pc(pc64),
      .illegal(illegal64)
   );

   // ---------------- scoreboard bookkeeping ----------------
   int checks   = 0;
   int failures = 0;

   // {illegal[131], fmt[130:128], imm64[127:64], pc[63:32], inst[31:0]}
   logic [131:0] exp_q[$];
   logic         accepted = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int fmt_of(input logic [6:0] op);
      case (op)
         7'h33:                      return 0;
         7'h13, 7'h03, 7'h67, 7'h73: return 1;
         7'h23:                      return 2;
         7'h63:                      return 3;
         7'h37, 7'h17:               return 4;
         7'h6F:                      return 5;
         default:                    return 7;
      endcase
   endfunction

   function automatic longint imm_of(input logic [31:0] i, input int f);
      longint v;
      v = 0;
      case (f)
         1: begin
            v = longint'(i[31:20]);
            if (v >= 2048) v -= 4096;
         end
         2: begin
            v = longint'(i[31:25]) * 32 + longint'(i[11:7]);
            if (v >= 2048) v -= 4096;
         end
         3: begin
            v = longint'(i[31]) * 4096 + longint'(i[7]) * 2048 +
                longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
            if (v >= 4096) v -= 8192;
         end
         4: begin
            v = longint'(i[31:12]) * 4096;
            if (v >= 64'sh8000_0000) v -= 64'sh1_0000_0000;
         end
         5: begin
            v = longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096 +
                longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
            if (v >= 1048576) v -= 2097152;
         end
         default: v = 0;
      endcase
      return v;
   endfunction

   function automatic logic illegal_of(input logic [31:0] i);
`ifdef INST_DECODE_ILLEGAL_CHK_EN
      int f;
      f = fmt_of(i[6:0]);
      if (f == 7) return 1'b1;
      if (f == 0 && i[31:25] != 7'h00 && i[31:25] != 7'h20) return 1'b1;
      if (i[6:0] == 7'h67 && i[14:12] != 3'd0) return 1'b1;
      return 1'b0;
`else
      return (i[31:0] == 32'hFFFF_FFFF) && 1'b0;
`endif
   endfunction

   function automatic logic [131:0] make_exp(input logic [31:0] i, input logic [31:0] p);
      int     f;
      longint v;
      logic [2:0] f3b;
      f   = fmt_of(i[6:0]);
      v   = imm_of(i, f);
      f3b = 3'(f);
      return {illegal_of(i), f3b, 64'(v), p, i};
   endfunction

   // Model of the stage's transfer rules, evaluated on each edge from the
   // stimulus and the model's own occupancy only.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q.delete();
         accepted <= 1'b0;
      end else begin
         accepted <= 1'b0;
         if (flush) begin
            exp_q.delete();
         end else begin
            if (in_valid && (exp_q.size() == 0 || out_ready)) begin
               if (exp_q.size() != 0) void'(exp_q.pop_front());
               exp_q.push_back(make_exp(in_inst, in_pc));
               accepted <= 1'b1;
            end else if (exp_q.size() != 0 && out_ready) begin
               void'(exp_q.pop_front());
            end
         end
      end
   end

   // Monitor: compares the presented bundle with the queue head every cycle,
   // so held bundles must stay stable and none may be lost or duplicated.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("in_ready", 64'(in_ready), 64'(exp_q.size() == 0 || out_ready));
         chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
         chk("out_valid64", 64'(out_valid64), 64'(exp_q.size() != 0));
         if (exp_q.size() != 0 && out_valid) begin
            chk("opcode", 64'(opcode), 64'(exp_q[0][6:0]));
            chk("rd",     64'(rd),     64'(exp_q[0][11:7]));
            chk("func3",  64'(func3),  64'(exp_q[0][14:12]));
            chk("rs1",    64'(rs1),    64'(exp_q[0][19:15]));
            chk("rs2",    64'(rs2),    64'(exp_q[0][24:20]));
            chk("func7",  64'(func7),  64'(exp_q[0][31:25]));
            chk("pc",     64'(pc),     64'(exp_q[0][63:32]));
            chk("imm32",  64'(imm),    64'(exp_q[0][95:64]));
            chk("imm64",  imm64,       exp_q[0][127:64]);
            chk("fmt",    64'(fmt),    64'(exp_q[0][130:128]));
            chk("illegal", 64'(illegal), 64'(exp_q[0][131]));
         end
      end
   end

   // ---------------- driver ----------------
   task automatic step(input logic v, input logic [31:0] i, input logic [31:0] p,
                       input logic f, input logic r);
      in_valid  = v;
      in_inst   = i;
      in_pc     = p;
      flush     = f;
      out_ready = r;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_inst();
      logic [6:0]  ops [0:9];
      logic [31:0] i;
      int k;
      ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
      i = $urandom;
      k = $urandom_range(0, 11);
      if (k <= 9) i[6:0] = ops[k];
      if (i[6:0] == 7'h33 && $urandom_range(0, 3) != 0)
         i[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
      if (i[6:0] == 7'h67 && $urandom_range(0, 1) == 0)
         i[14:12] = 3'd0;
      return i;
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      logic        have;
      logic [31:0] p_inst, p_pc;
      logic        fl;

      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd1);
      chk("rst_fmt",       64'(fmt),       64'd7);
      chk("rst_imm",       64'(imm),       64'd0);
      chk("rst_pc",        64'(pc),        64'd0);
      chk("rst_opcode",    64'(opcode),    64'd0);
      chk("rst_illegal",   64'(illegal),   64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // addi x1,x2,-1
      step(1'b1, 32'hFFF1_0093, 32'h0000_0100, 1'b0, 1'b1);
      chk("addi_valid", 64'(out_valid), 64'd1);
      chk("addi_fmt",   64'(fmt),       64'd1);
      chk("addi_rd",    64'(rd),        64'd1);
      chk("addi_rs1",   64'(rs1),       64'd2);
      chk("addi_func3", 64'(func3),     64'd0);
      chk("addi_imm",   64'(imm),       64'hFFFF_FFFF);
      chk("addi_pc",    64'(pc),        64'h100);

      // back-to-back sw, beq, lui
      step(1'b1, 32'h0051_2423, 32'h104, 1'b0, 1'b1);
      chk("sw_fmt", 64'(fmt), 64'd2);
      chk("sw_imm", 64'(imm), 64'd8);
      chk("sw_rs2", 64'(rs2), 64'd5);
      chk("sw_in_ready", 64'(in_ready), 64'd1);
      step(1'b1, 32'hFE00_0EE3, 32'h108, 1'b0, 1'b1);
      chk("beq_fmt",   64'(fmt), 64'd3);
      chk("beq_imm",   64'(imm), 64'hFFFF_FFFC);
      chk("beq_imm64", imm64,    64'hFFFF_FFFF_FFFF_FFFC);
      chk("beq_in_ready", 64'(in_ready), 64'd1);
      step(1'b1, 32'h1234_50B7, 32'h10C, 1'b0, 1'b1);
      chk("lui_fmt", 64'(fmt), 64'd4);
      chk("lui_imm", 64'(imm), 64'h1234_5000);
      chk("lui_in_ready", 64'(in_ready), 64'd1);

      // downstream stall for 3 cycles with a new instruction waiting
      step(1'b1, 32'h00A0_0093, 32'h110, 1'b0, 1'b1);
      for (int c = 0; c < 3; c++) begin
         step(1'b1, 32'h0020_8133, 32'h114, 1'b0, 1'b0);
         chk("stall_in_ready", 64'(in_ready), 64'd0);
         chk("stall_imm",      64'(imm),      64'd10);
         chk("stall_pc",       64'(pc),       64'h110);
      end
      step(1'b1, 32'h0020_8133, 32'h114, 1'b0, 1'b1);
      chk("release_fmt", 64'(fmt), 64'd0);
      chk("release_rd",  64'(rd),  64'd2);
      chk("release_pc",  64'(pc),  64'h114);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      chk("drained_valid", 64'(out_valid), 64'd0);

      // flush during a stall with a new instruction offered
      step(1'b1, 32'h0000_0513, 32'h200, 1'b0, 1'b1);
      step(1'b1, 32'h0051_2423, 32'h204, 1'b0, 1'b0);
      step(1'b1, 32'h0051_2423, 32'h204, 1'b1, 1'b0);
      chk("flush_valid", 64'(out_valid), 64'd0);
      chk("flush_pc_hold", 64'(pc), 64'h200);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      chk("flush_not_captured", 64'(out_valid), 64'd0);

      // unknown opcode
      step(1'b1, 32'h0000_007F, 32'h300, 1'b0, 1'b1);
      chk("unk_fmt", 64'(fmt), 64'd7);
      chk("unk_imm", 64'(imm), 64'd0);
`ifdef INST_DECODE_ILLEGAL_CHK_EN
      chk("unk_illegal", 64'(illegal), 64'd1);
`else
      chk("unk_illegal", 64'(illegal), 64'd0);
`endif

      // asynchronous reset in the middle of a stall
      step(1'b1, 32'hFFF1_0093, 32'h400, 1'b0, 1'b1);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_in_ready",  64'(in_ready),  64'd1);
      chk("arst_fmt",       64'(fmt),       64'd7);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

      // randomized traffic
      have = 1'b0;
      p_inst = '0;
      p_pc = '0;
      for (int c = 0; c < 3000; c++) begin
         if (!have && $urandom_range(0, 3) != 0) begin
            p_inst = rand_inst();
            p_pc   = $urandom;
            have   = 1'b1;
         end
         fl = ($urandom_range(0, 19) == 0);
         step(have, p_inst, p_pc, fl, ($urandom_range(0, 9) < 7));
         if (fl || accepted) have = 1'b0;
      end
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      chk("final_empty", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
